// File: rtl/spi_slave_if.sv
// Pin-side and host-side signal bundle for the SPI target controller.
// The slave modport is the controller's view; the master modport is the far side (pins + host).
interface spi_slave_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_i;
  logic [DATA_W-1:0] rx_o;
  logic              busy_o;
  logic              irq_o;
  logic              ovr_o;
  logic              ack_i;
  logic              cpol_i;
  logic              cpha_i;
  logic              dord_i;
  logic              sclk_i;
  logic              ss_n_i;
  logic              mosi_i;
  logic              miso_o;
  logic              miso_en_o;

  modport slave (
    input  tx_i, ack_i, cpol_i, cpha_i, dord_i, sclk_i, ss_n_i, mosi_i,
    output rx_o, busy_o, irq_o, ovr_o, miso_o, miso_en_o
  );

  modport master (
    output tx_i, ack_i, cpol_i, cpha_i, dord_i, sclk_i, ss_n_i, mosi_i,
    input  rx_o, busy_o, irq_o, ovr_o, miso_o, miso_en_o
  );
endinterface

// File: rtl/spi_slave.sv
// SPI target controller: over-samples SCK/SS_N/MOSI with clk_i, shifts DATA_W-bit words
// in any CPOL/CPHA/bit order and hands received words over with an IRQ/ACK handshake.
module spi_slave #(
  parameter int DATA_W = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  spi_slave_if.slave bus
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic               sclk_p0, sclk_p1, sclk_p2;
  logic               ss_n_p0, ss_n_p1, ss_n_p2;
  logic               mosi_p0, mosi_p1;
  logic               mosi_r;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  rx_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic               irq_q, ovr_q;
  logic               nsck_p1, nsck_p2;
  logic               lead, trail, ss_fall, ss_rise;
  logic               last_bit, in_bit, run, done;

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w,
                                                   input logic              b,
                                                   input logic              lsb_first);
    return lsb_first ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  // Stage p0/p1: two-flop synchronizers; p2: one more flop on SCK/SS_N for edge detect
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_p0 <= bus.cpol_i;
      sclk_p1 <= bus.cpol_i;
      sclk_p2 <= bus.cpol_i;
      ss_n_p0 <= 1'b1;
      ss_n_p1 <= 1'b1;
      ss_n_p2 <= 1'b1;
    end else begin
      sclk_p0 <= bus.sclk_i;
      sclk_p1 <= sclk_p0;
      sclk_p2 <= sclk_p1;
      ss_n_p0 <= bus.ss_n_i;
      ss_n_p1 <= ss_n_p0;
      ss_n_p2 <= ss_n_p1;
    end
  end

  always_ff @(posedge clk_i) begin
    mosi_p0 <= bus.mosi_i;
    mosi_p1 <= mosi_p0;
  end

  // Edge decode on the synchronized samples; SCK is normalised so "leading" is polarity-free
  always_comb begin
    nsck_p1  = sclk_p1 ^ bus.cpol_i;
    nsck_p2  = sclk_p2 ^ bus.cpol_i;
    lead     = nsck_p1 & ~nsck_p2;
    trail    = ~nsck_p1 & nsck_p2;
    ss_fall  = ss_n_p2 & ~ss_n_p1;
    ss_rise  = ~ss_n_p2 & ss_n_p1;
    last_bit = (bit_cnt == CNT_W'(DATA_W - 1));
    // With CPHA=1 the final bit never gets a following leading edge, so take it straight from the pin
    in_bit   = bus.cpha_i ? mosi_p1 : mosi_r;
    run      = (state_q == ACTIVE) & ~ss_rise;
    done     = run & trail & last_bit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = ACTIVE;
      ACTIVE:  if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o    = (state_q == ACTIVE);
    bus.miso_en_o = (state_q == ACTIVE);
    bus.miso_o    = bus.dord_i ? shreg[0] : shreg[DATA_W-1];
    bus.rx_o      = rx_q;
    bus.irq_o     = irq_q;
    bus.ovr_o     = ovr_q;
  end

  always_ff @(posedge clk_i) begin
    if (run) begin
      if (lead && !bus.cpha_i)
        mosi_r <= mosi_p1;
      else if (trail && bus.cpha_i)
        mosi_r <= mosi_p1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg   <= '0;
      bit_cnt <= '0;
      rx_q    <= '0;
    end else if (state_q == IDLE) begin
      if (ss_fall) begin
        shreg   <= bus.tx_i;
        bit_cnt <= '0;
      end
    end else if (run) begin
      if (lead && bus.cpha_i && bit_cnt != '0) begin
        shreg <= shift_word(shreg, mosi_r, bus.dord_i);
      end else if (trail) begin
        if (last_bit) begin
          rx_q    <= shift_word(shreg, in_bit, bus.dord_i);
          shreg   <= bus.tx_i;
          bit_cnt <= '0;
        end else begin
          if (!bus.cpha_i) shreg <= shift_word(shreg, mosi_r, bus.dord_i);
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // A completion in the same cycle as ack_i keeps irq set; overrun only counts unacknowledged words
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
      ovr_q <= 1'b0;
    end else if (done) begin
      irq_q <= 1'b1;
      ovr_q <= bus.ack_i ? 1'b0 : (ovr_q | irq_q);
    end else if (bus.ack_i) begin
      irq_q <= 1'b0;
      ovr_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged SPI master drives the pins in every mode
// and checks both directions of the loopback plus the IRQ/overrun/abort/reset behaviour.
module tb_spi_slave;

  localparam int H = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(8)) bus();

  spi_slave #(.DATA_W(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] mrx;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic cpol, input logic cpha, input logic dord);
    bus.cpol_i = cpol;
    bus.cpha_i = cpha;
    bus.dord_i = dord;
    bus.sclk_i = cpol;
    wait_clk(4);
  endtask

  task automatic ss_low();
    bus.ss_n_i = 1'b0;
    wait_clk(H);
  endtask

  task automatic ss_high();
    bus.ss_n_i = 1'b1;
    wait_clk(H);
  endtask

  task automatic ack_pulse();
    bus.ack_i = 1'b1;
    wait_clk(1);
    bus.ack_i = 1'b0;
    wait_clk(1);
  endtask

  // Each bit ends on the trailing SCK edge; ack_last lands ack_i exactly in the completion cycle
  task automatic spi_word(input logic [7:0] mtx, input int nbits, input bit ack_last,
                          output logic [7:0] rxw);
    int pos;
    rxw = '0;
    for (int i = 0; i < nbits; i++) begin
      pos = bus.dord_i ? i : 7 - i;
      if (!bus.cpha_i) begin
        bus.mosi_i = mtx[pos];
        wait_clk(H);
        bus.sclk_i = ~bus.cpol_i;
        rxw[pos]   = bus.miso_o;
        wait_clk(H);
        bus.sclk_i = bus.cpol_i;
      end else begin
        bus.sclk_i = ~bus.cpol_i;
        bus.mosi_i = mtx[pos];
        wait_clk(H);
        bus.sclk_i = bus.cpol_i;
        rxw[pos]   = bus.miso_o;
      end
      if (ack_last && i == nbits - 1) begin
        wait_clk(2);
        bus.ack_i = 1'b1;
        wait_clk(1);
        bus.ack_i = 1'b0;
        wait_clk(H - 3);
      end else begin
        wait_clk(H);
      end
    end
  endtask

  task automatic xfer(input logic [7:0] mtx, input logic [7:0] stx, output logic [7:0] rxw);
    bus.tx_i = stx;
    ss_low();
    spi_word(mtx, 8, 1'b0, rxw);
    ss_high();
  endtask

  initial begin
    rst        = 1'b1;
    bus.tx_i   = 8'h00;
    bus.ack_i  = 1'b0;
    bus.cpol_i = 1'b0;
    bus.cpha_i = 1'b0;
    bus.dord_i = 1'b0;
    bus.sclk_i = 1'b0;
    bus.ss_n_i = 1'b1;
    bus.mosi_i = 1'b0;
    wait_clk(3);
    chk("rst_rx",   bus.rx_o, 8'h00);
    chk("rst_irq",  {7'd0, bus.irq_o}, 8'h00);
    chk("rst_ovr",  {7'd0, bus.ovr_o}, 8'h00);
    chk("rst_busy", {7'd0, bus.busy_o}, 8'h00);
    chk("rst_oen",  {7'd0, bus.miso_en_o}, 8'h00);
    rst = 1'b0;
    wait_clk(2);

    // Mode 0, MSB first
    set_mode(1'b0, 1'b0, 1'b0);
    bus.tx_i = 8'h3C;
    ss_low();
    chk("t1_busy", {7'd0, bus.busy_o}, 8'h01);
    chk("t1_oen",  {7'd0, bus.miso_en_o}, 8'h01);
    spi_word(8'hA5, 8, 1'b0, mrx);
    ss_high();
    chk("t1_rx",    bus.rx_o, 8'hA5);
    chk("t1_mrx",   mrx, 8'h3C);
    chk("t1_irq",   {7'd0, bus.irq_o}, 8'h01);
    chk("t1_ovr",   {7'd0, bus.ovr_o}, 8'h00);
    chk("t1_idle",  {7'd0, bus.busy_o}, 8'h00);
    ack_pulse();
    chk("t1_ack",   {7'd0, bus.irq_o}, 8'h00);

    // Every CPOL/CPHA/DORD combination, symmetric and asymmetric patterns
    for (int m = 0; m < 8; m++) begin
      set_mode(m[0], m[1], m[2]);
      xfer(8'h81, 8'h7E, mrx);
      chk($sformatf("t2_rx_a_m%0d", m),  bus.rx_o, 8'h81);
      chk($sformatf("t2_mrx_a_m%0d", m), mrx, 8'h7E);
      ack_pulse();
      xfer(8'h1D, 8'hC6, mrx);
      chk($sformatf("t2_rx_b_m%0d", m),  bus.rx_o, 8'h1D);
      chk($sformatf("t2_mrx_b_m%0d", m), mrx, 8'hC6);
      ack_pulse();
    end

    // Two words under one SS_N, no ack in between -> overrun
    set_mode(1'b1, 1'b1, 1'b0);
    bus.tx_i = 8'h5A;
    ss_low();
    spi_word(8'h12, 8, 1'b0, mrx);
    chk("t3_rx1",  bus.rx_o, 8'h12);
    chk("t3_ovr1", {7'd0, bus.ovr_o}, 8'h00);
    spi_word(8'h34, 8, 1'b0, mrx);
    ss_high();
    chk("t3_rx2",  bus.rx_o, 8'h34);
    chk("t3_mrx2", mrx, 8'h5A);
    chk("t3_irq",  {7'd0, bus.irq_o}, 8'h01);
    chk("t3_ovr",  {7'd0, bus.ovr_o}, 8'h01);
    ack_pulse();
    chk("t3_irq_ack", {7'd0, bus.irq_o}, 8'h00);
    chk("t3_ovr_ack", {7'd0, bus.ovr_o}, 8'h00);

    // SS_N released after 3 bits
    set_mode(1'b0, 1'b0, 1'b0);
    bus.tx_i = 8'h00;
    ss_low();
    spi_word(8'hFF, 3, 1'b0, mrx);
    bus.ss_n_i = 1'b1;
    wait_clk(4);
    chk("t4_busy", {7'd0, bus.busy_o}, 8'h00);
    chk("t4_rx",   bus.rx_o, 8'h34);
    chk("t4_irq",  {7'd0, bus.irq_o}, 8'h00);
    wait_clk(H);
    xfer(8'hC3, 8'h99, mrx);
    chk("t4_rx_next",  bus.rx_o, 8'hC3);
    chk("t4_mrx_next", mrx, 8'h99);
    ack_pulse();

    // ack_i coincides with completion of the second word
    bus.tx_i = 8'h0F;
    ss_low();
    spi_word(8'h11, 8, 1'b0, mrx);
    chk("t5_irq1", {7'd0, bus.irq_o}, 8'h01);
    spi_word(8'h22, 8, 1'b1, mrx);
    chk("t5_irq", {7'd0, bus.irq_o}, 8'h01);
    chk("t5_ovr", {7'd0, bus.ovr_o}, 8'h00);
    chk("t5_rx",  bus.rx_o, 8'h22);
    ss_high();

    // Reset pulsed mid-word
    bus.tx_i = 8'hE7;
    ss_low();
    spi_word(8'hF0, 4, 1'b0, mrx);
    rst        = 1'b1;
    bus.ss_n_i = 1'b1;
    bus.sclk_i = bus.cpol_i;
    wait_clk(1);
    chk("t6_rx",   bus.rx_o, 8'h00);
    chk("t6_irq",  {7'd0, bus.irq_o}, 8'h00);
    chk("t6_ovr",  {7'd0, bus.ovr_o}, 8'h00);
    chk("t6_busy", {7'd0, bus.busy_o}, 8'h00);
    chk("t6_oen",  {7'd0, bus.miso_en_o}, 8'h00);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    xfer(8'h55, 8'hAA, mrx);
    chk("t6_rx_next",  bus.rx_o, 8'h55);
    chk("t6_mrx_next", mrx, 8'hAA);
    chk("t6_irq_next", {7'd0, bus.irq_o}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
